pwm_sequencer: RTL and testbench
================================

// Module: pwm_sequencer
// PURPOSE
//  Steps a PWM generator through a programmable table of steps: duty, period limit, repeat count.
//  Drives the PWM's duty/limit inputs and its synchronous counter reset.
//  Changes settings only on period boundaries, so output pulses are never truncated.
//  Sits between the register interface (table writes, start/stop) and one PWM instance.
// PARAMETERS
//  NUM_STEPS  8   table depth (power of 2, >=2)
//  DW         16  duty/limit width; must match the PWM
//  RW         8   repeat-count width
// PORTS
//  clk        in   1          system clock; the only clock
//  rst        in   1          asynchronous, active-high reset
//  cfg_we     in   1          table write strobe
//  cfg_addr   in   log2(NS)   table entry index
//  cfg_duty   in   DW         step duty (high cycles per period)
//  cfg_limit  in   DW         step limit; period = limit+1 cycles
//  cfg_reps   in   RW         periods to run this step; 0 = skip step
//  seq_len    in   log2(NS)+1 steps in sequence, 1..NUM_STEPS; sampled on start
//  loop_en    in   1          1: wrap to step 0 after last step; sampled on start
//  start      in   1          start pulse; ignored unless IDLE
//  stop       in   1          abort; wins over start
//  busy       out  1          high in LOAD/RUN
//  done       out  1          1-cycle pulse when a non-looping sequence completes
//  step_idx   out  log2(NS)   index of current step
//  pwm_duty   out  DW         to PWM duty input
//  pwm_limit  out  DW         to PWM limit input
//  pwm_sync   out  1          to PWM reset; holds the PWM counter at 0
// BEHAVIOUR
//  Reset values: busy=0, done=0, step_idx=0, pwm_duty=0, pwm_limit=0, pwm_sync=1, FSM=IDLE.
//  Table contents are not reset.
//  FSM states: IDLE, LOAD, RUN.
//   IDLE -> LOAD   on start & ~stop.
//                  Latch seq_len (0 treated as 1) and loop_en; step=0.
//   LOAD (1 cycle) Read entry[step].
//                  reps==0: advance step (see end-of-step rule); stay in LOAD.
//                  else: pwm_duty/limit <= entry; period counter pc=0; rep counter rc=0; -> RUN.
//   RUN            pc increments each cycle.
//                  When pc==limit: pc<=0 and rc++.
//                  When also rc==reps-1: end of step.
//  End of step:
//   - step < len-1: step++ -> LOAD.
//   - step == len-1 and loop_en: step=0 -> LOAD.
//   - step == len-1, no loop: -> IDLE, done=1 for 1 cycle.
//  pwm_sync=1 in IDLE and LOAD, 0 in RUN.
//   - First RUN cycle has PWM count 0, aligned with pc=0.
//   - Each step boundary costs exactly 1 LOAD cycle.
//  IDLE output: pwm_duty=0, so PWM output is low.
//  Latency: start -> first PWM high cycle = 2 clocks (IDLE->LOAD->RUN).
//  stop in any state: -> IDLE next cycle; pwm_duty<=0, pwm_sync<=1; no done pulse.
//  Same-cycle stop and start: stop wins.
//  Same-cycle stop and end of step: stop wins; no done.
//  Table writes are accepted in any state; a rewritten entry takes effect at its next LOAD.
//  Entries at index >= seq_len are never read.
//  duty > limit is passed through unchanged (PWM output stays high all period).
//  duty = 0 gives a low output.
//  All counters are unsigned, width DW/RW; pc never exceeds the latched limit.
// CONFIGURATION
//  PWM_SEQ_IRQ_EN defined:
//   - adds ports irq (out, 1) and irq_clr (in, 1).
//   - irq is set on done or stop-abort and stays set until irq_clr.
//   - set wins over a same-cycle clear; irq resets to 0.
//  Not defined: ports absent; no irq logic.
// STRUCTURE
//  pwm_seq_pkg: state_t enum {IDLE, LOAD, RUN}; step_t struct {duty, limit, reps};
//   default widths DW=16, RW=8.
//  Sub-module pwm_seq_table: NUM_STEPS x step_t register file,
//   1 synchronous write port, 1 combinational read port.
// TESTING
//  1. Entry0 {duty=2, limit=4, reps=3}, seq_len=1, start
//     -> busy 2..17; 3 periods of 5 cycles, 2 high each; done at cycle 18.
//  2. Entries {1,3,2}, {3,3,1}, seq_len=2
//     -> 2x(1H3L), 1 LOAD cycle, 1x(3H1L), then done.
//  3. Entry1 reps=0, seq_len=3 -> step_idx goes 0 -> 2; step 1 produces no output.
//  4. loop_en=1, 2 steps -> step_idx wraps 1 -> 0 with no done; stop mid-period
//     -> pwm_sync=1 and PWM output low next cycle.
//  5. Assert rst mid-RUN -> all outputs at reset values immediately; a later start
//     reruns from step 0.
//  6. Write entry1 during step 0 -> new values used at entry1's LOAD.
//     With PWM_SEQ_IRQ_EN: irq set after done, cleared by irq_clr.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_seq_pkg
//  Purpose  : Shared types and default widths for the PWM step sequencer:
//             FSM state encoding and the layout of one table entry.
//  Revision : 1.0  initial release
// ============================================================================
package pwm_seq_pkg;

  // Default duty/limit width (must match the driven PWM) and repeat width.
  localparam int unsigned c_DEF_DW = 16;
  localparam int unsigned c_DEF_RW = 8;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // One table entry at the default widths.
  typedef struct packed {
    logic [c_DEF_DW-1:0] duty;
    logic [c_DEF_DW-1:0] limit;
    logic [c_DEF_RW-1:0] reps;
  } step_t;

endpackage
`default_nettype wire

// File: rtl/pwm_seq_table.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_seq_table
//  Purpose  : NUM_STEPS-deep step table (duty, limit, repeat count) with one
//             synchronous write port and one combinational read port.
//             Contents are deliberately not reset.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_seq_table #(
  parameter int  NUM_STEPS = 8,
  parameter int  DW        = 16,
  parameter int  RW        = 8,
  localparam int AW        = $clog2(NUM_STEPS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wduty,
  input  logic [DW-1:0] i_wlimit,
  input  logic [RW-1:0] i_wreps,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rduty,
  output logic [DW-1:0] o_rlimit,
  output logic [RW-1:0] o_rreps
);

  logic [DW-1:0] r_duty  [NUM_STEPS];
  logic [DW-1:0] r_limit [NUM_STEPS];
  logic [RW-1:0] r_reps  [NUM_STEPS];

  // Write port: storage only, so no reset is applied to the entries.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_duty[i_waddr]  <= i_wduty;
      r_limit[i_waddr] <= i_wlimit;
      r_reps[i_waddr]  <= i_wreps;
    end
  end

  assign o_rduty  = r_duty[i_raddr];
  assign o_rlimit = r_limit[i_raddr];
  assign o_rreps  = r_reps[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pwm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_sequencer
//  Purpose  : Steps one PWM generator through a programmable table of
//             {duty, limit, repeat} steps. Settings change only on period
//             boundaries; the PWM counter is held at 0 (o_pwm_sync) outside
//             RUN so every step starts on a clean period.
//  Options  : PWM_SEQ_IRQ_EN - adds sticky o_irq (set on done or on a stop
//             that aborts an active sequence) and its clear input i_irq_clr.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int  NUM_STEPS = 8,
  parameter int  DW        = c_DEF_DW,
  parameter int  RW        = c_DEF_RW,
  localparam int AW        = $clog2(NUM_STEPS),
  localparam int LW        = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cfg_we,
  input  logic [AW-1:0] i_cfg_addr,
  input  logic [DW-1:0] i_cfg_duty,
  input  logic [DW-1:0] i_cfg_limit,
  input  logic [RW-1:0] i_cfg_reps,
  input  logic [LW-1:0] i_seq_len,
  input  logic          i_loop_en,
  input  logic          i_start,
  input  logic          i_stop,
`ifdef PWM_SEQ_IRQ_EN
  input  logic          i_irq_clr,
  output logic          o_irq,
`endif
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_step_idx,
  output logic [DW-1:0] o_pwm_duty,
  output logic [DW-1:0] o_pwm_limit,
  output logic          o_pwm_sync
);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-1:0] r_step,  w_step_nxt;
  logic [LW-1:0] r_len,   w_len_nxt;
  logic          r_loop,  w_loop_nxt;
  logic [DW-1:0] r_duty,  w_duty_nxt;
  logic [DW-1:0] r_limit, w_limit_nxt;
  logic [RW-1:0] r_reps,  w_reps_nxt;
  logic [DW-1:0] r_pc,    w_pc_nxt;
  logic [RW-1:0] r_rc,    w_rc_nxt;
  logic          r_done,  w_done_nxt;

  logic          w_step_end;
  logic          w_last;
  logic [LW-1:0] w_len_start;
  logic [DW-1:0] w_rd_duty;
  logic [DW-1:0] w_rd_limit;
  logic [RW-1:0] w_rd_reps;

  pwm_seq_table #(
    .NUM_STEPS (NUM_STEPS),
    .DW        (DW),
    .RW        (RW)
  ) u_table (
    .clk      (clk),
    .i_we     (i_cfg_we),
    .i_waddr  (i_cfg_addr),
    .i_wduty  (i_cfg_duty),
    .i_wlimit (i_cfg_limit),
    .i_wreps  (i_cfg_reps),
    .i_raddr  (r_step),
    .o_rduty  (w_rd_duty),
    .o_rlimit (w_rd_limit),
    .o_rreps  (w_rd_reps)
  );

  // Sequence length captured at start: 0 runs one step, oversize clamps to table depth.
  always_comb begin
    w_len_start = i_seq_len;
    if (i_seq_len == '0) begin
      w_len_start = LW'(1);
    end else if (i_seq_len > LW'(NUM_STEPS)) begin
      w_len_start = LW'(NUM_STEPS);
    end
  end

  assign w_last = ({1'b0, r_step} == (r_len - LW'(1)));

  // Next-state and datapath decode; stop overrides everything and freezes step/limit.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_len_nxt   = r_len;
    w_loop_nxt  = r_loop;
    w_duty_nxt  = r_duty;
    w_limit_nxt = r_limit;
    w_reps_nxt  = r_reps;
    w_pc_nxt    = r_pc;
    w_rc_nxt    = r_rc;
    w_done_nxt  = 1'b0;
    w_step_end  = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = LOAD;
          w_len_nxt   = w_len_start;
          w_loop_nxt  = i_loop_en;
          w_step_nxt  = '0;
        end
      end
      LOAD: begin
        if (w_rd_reps == '0) begin
          w_step_end = 1'b1;
        end else begin
          w_duty_nxt  = w_rd_duty;
          w_limit_nxt = w_rd_limit;
          w_reps_nxt  = w_rd_reps;
          w_pc_nxt    = '0;
          w_rc_nxt    = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_pc == r_limit) begin
          w_pc_nxt = '0;
          w_rc_nxt = r_rc + RW'(1);
          if (r_rc == (r_reps - RW'(1))) begin
            w_step_end = 1'b1;
          end
        end else begin
          w_pc_nxt = r_pc + DW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_step_end) begin
      if (!w_last) begin
        w_step_nxt  = r_step + AW'(1);
        w_state_nxt = LOAD;
      end else if (r_loop) begin
        w_step_nxt  = '0;
        w_state_nxt = LOAD;
      end else begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_duty_nxt  = '0;
      end
    end

    if (i_stop) begin
      w_state_nxt = IDLE;
      w_duty_nxt  = '0;
      w_done_nxt  = 1'b0;
      w_step_nxt  = r_step;
      w_limit_nxt = r_limit;
      w_len_nxt   = r_len;
      w_loop_nxt  = r_loop;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Step, counter and PWM-setting registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step  <= '0;
      r_len   <= LW'(1);
      r_loop  <= 1'b0;
      r_duty  <= '0;
      r_limit <= '0;
      r_reps  <= '0;
      r_pc    <= '0;
      r_rc    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_step  <= w_step_nxt;
      r_len   <= w_len_nxt;
      r_loop  <= w_loop_nxt;
      r_duty  <= w_duty_nxt;
      r_limit <= w_limit_nxt;
      r_reps  <= w_reps_nxt;
      r_pc    <= w_pc_nxt;
      r_rc    <= w_rc_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef PWM_SEQ_IRQ_EN
  logic r_irq;
  logic w_irq_set;

  assign w_irq_set = w_done_nxt | (i_stop & (r_state != IDLE));

  // Sticky interrupt: a new event wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_irq <= 1'b1;
    end else if (i_irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign o_irq = r_irq;
`endif

  assign o_busy      = (r_state != IDLE);
  assign o_pwm_sync  = (r_state != RUN);
  assign o_done      = r_done;
  assign o_step_idx  = r_step;
  assign o_pwm_duty  = r_duty;
  assign o_pwm_limit = r_limit;

endmodule
`default_nettype wire

// File: tb/tb_pwm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_sequencer
//  Purpose  : Self-checking bench for pwm_sequencer. A queue-based model
//             expands each table step into its expected per-cycle outputs;
//             directed scenarios add hand-computed timing/count checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_sequencer;
  import pwm_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_cfg_we;
  logic [2:0]  i_cfg_addr;
  logic [15:0] i_cfg_duty;
  logic [15:0] i_cfg_limit;
  logic [7:0]  i_cfg_reps;
  logic [3:0]  i_seq_len;
  logic        i_loop_en;
  logic        i_start;
  logic        i_stop;
`ifdef PWM_SEQ_IRQ_EN
  logic        i_irq_clr;
  logic        o_irq;
  logic        m_irq;
`endif
  logic        o_busy;
  logic        o_done;
  logic [2:0]  o_step_idx;
  logic [15:0] o_pwm_duty;
  logic [15:0] o_pwm_limit;
  logic        o_pwm_sync;

  pwm_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_duty  (i_cfg_duty),
    .i_cfg_limit (i_cfg_limit),
    .i_cfg_reps  (i_cfg_reps),
    .i_seq_len   (i_seq_len),
    .i_loop_en   (i_loop_en),
    .i_start     (i_start),
    .i_stop      (i_stop),
`ifdef PWM_SEQ_IRQ_EN
    .i_irq_clr   (i_irq_clr),
    .o_irq       (o_irq),
`endif
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_step_idx  (o_step_idx),
    .o_pwm_duty  (o_pwm_duty),
    .o_pwm_limit (o_pwm_limit),
    .o_pwm_sync  (o_pwm_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple PWM driven by the sequencer: counter held at 0 by sync, high while count < duty.
  logic [15:0] tb_cnt;
  logic        tb_hi;
  always @(posedge clk or posedge rst) begin
    if (rst)                    tb_cnt <= '0;
    else if (o_pwm_sync)        tb_cnt <= '0;
    else if (tb_cnt >= o_pwm_limit) tb_cnt <= '0;
    else                        tb_cnt <= tb_cnt + 16'd1;
  end
  assign tb_hi = !o_pwm_sync && (tb_cnt < o_pwm_duty);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        busy;
    logic        sync;
    logic        done;
    logic        hi;
    logic [15:0] duty;
    logic [15:0] limit;
    logic [2:0]  step;
  } exp_t;

  step_t m_tab [8];
  exp_t  m_q [$];
  exp_t  m_prev;
  bit    m_active = 1'b0;
  int    m_step = 0;
  int    m_len  = 1;
  bit    m_loop = 1'b0;

  // Expand the current step into its LOAD cycle, its RUN periods and, at the
  // end of a non-looping sequence, the done cycle.
  task automatic expand();
    step_t ent;
    exp_t  x;
    int    s;
    s   = m_step;
    ent = m_tab[s];
    x = m_prev;
    x.busy = 1'b1; x.sync = 1'b1; x.done = 1'b0; x.hi = 1'b0; x.step = 3'(s);
    m_q.push_back(x);
    for (int r = 0; r < int'(ent.reps); r++) begin
      for (int p = 0; p <= int'(ent.limit); p++) begin
        x.busy = 1'b1; x.sync = 1'b0; x.done = 1'b0;
        x.hi = (p < int'(ent.duty));
        x.duty = ent.duty; x.limit = ent.limit; x.step = 3'(s);
        m_q.push_back(x);
      end
    end
    if (s < m_len - 1) begin
      m_step = s + 1;
    end else if (m_loop) begin
      m_step = 0;
    end else begin
      x.busy = 1'b0; x.sync = 1'b1; x.done = 1'b1; x.hi = 1'b0; x.duty = '0;
      m_q.push_back(x);
      m_active = 1'b0;
    end
  endtask

  // Compare process: check this cycle, then fold in the inputs seen at the next edge.
  always @(negedge clk) begin : p_cmp
    exp_t e;
    int   l;
    bit   set_irq;
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      e = '{busy: 1'b0, sync: 1'b1, done: 1'b0, hi: 1'b0, duty: 16'h0, limit: 16'h0, step: 3'h0};
`ifdef PWM_SEQ_IRQ_EN
      m_irq = 1'b0;
`endif
    end else begin
      if (m_q.size() == 0 && m_active) expand();
      if (m_q.size() != 0) begin
        e = m_q.pop_front();
      end else begin
        e = m_prev;
        e.busy = 1'b0; e.sync = 1'b1; e.done = 1'b0; e.hi = 1'b0; e.duty = '0;
      end
    end
    chk("cycle{busy,sync,done,hi,duty,limit,step}",
        {o_busy, o_pwm_sync, o_done, tb_hi, o_pwm_duty, o_pwm_limit, o_step_idx}, e);
`ifdef PWM_SEQ_IRQ_EN
    chk("irq", o_irq, m_irq);
`endif
    m_prev = e;
    if (!rst) begin
      set_irq = i_stop ? e.busy : (m_q.size() != 0 && m_q[0].done);
`ifdef PWM_SEQ_IRQ_EN
      if (set_irq) m_irq = 1'b1;
      else if (i_irq_clr) m_irq = 1'b0;
`endif
      if (i_cfg_we) m_tab[i_cfg_addr] = '{duty: i_cfg_duty, limit: i_cfg_limit, reps: i_cfg_reps};
      if (i_stop) begin
        m_q.delete();
        m_active = 1'b0;
      end else if (i_start && !e.busy) begin
        l = int'(i_seq_len);
        if (l == 0) l = 1;
        if (l > 8)  l = 8;
        m_active = 1'b1;
        m_step   = 0;
        m_len    = l;
        m_loop   = i_loop_en;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int busy_n, hi_n, load_n, done_n, d2_n, first_hi_k, last_busy_k, done_k;
  int run_step [8];

  task automatic write_entry(input int a, input int d, input int l, input int r);
    @(posedge clk); #1;
    i_cfg_we = 1'b1; i_cfg_addr = 3'(a); i_cfg_duty = 16'(d); i_cfg_limit = 16'(l); i_cfg_reps = 8'(r);
    @(posedge clk); #1;
    i_cfg_we = 1'b0;
  endtask

  // Start pulse is cycle 1; returns during cycle 2.
  task automatic start_seq(input int len, input bit lp);
    @(posedge clk); #1;
    i_seq_len = 4'(len); i_loop_en = lp; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Observe from cycle 2 until done (bounded); k is the cycle number.
  task automatic measure(input int max_cyc);
    bit fin;
    fin = 1'b0;
    busy_n = 0; hi_n = 0; load_n = 0; done_n = 0; d2_n = 0;
    first_hi_k = 0; last_busy_k = 0; done_k = 0;
    for (int s = 0; s < 8; s++) run_step[s] = 0;
    for (int k = 2; k < 2 + max_cyc && !fin; k++) begin
      @(negedge clk);
      if (o_busy) begin busy_n++; last_busy_k = k; end
      if (o_busy && o_pwm_sync) load_n++;
      if (o_busy && !o_pwm_sync) begin
        run_step[o_step_idx]++;
        if (o_pwm_duty == 16'd2) d2_n++;
      end
      if (tb_hi) begin hi_n++; if (first_hi_k == 0) first_hi_k = k; end
      if (o_done) begin done_n++; done_k = k; fin = 1'b1; end
    end
    chk("measure_done_seen", fin, 1'b1);
  endtask

  initial begin : p_drv
    int wraps, dn, prev;
    bit found;
    rst = 1'b1; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_duty = '0; i_cfg_limit = '0;
    i_cfg_reps = '0; i_seq_len = 4'd1; i_loop_en = 1'b0; i_start = 1'b0; i_stop = 1'b0;
`ifdef PWM_SEQ_IRQ_EN
    i_irq_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_sync", o_pwm_sync, 1'b1);
    chk("reset_duty", o_pwm_duty, 16'h0);
    chk("reset_step", o_step_idx, 3'h0);

    // 1: single step {2,4,3}
    write_entry(0, 2, 4, 3);
    start_seq(1, 1'b0);
    measure(40);
    chk("t1_first_high_cycle", first_hi_k, 3);
    chk("t1_last_busy_cycle", last_busy_k, 17);
    chk("t1_done_cycle", done_k, 18);
    chk("t1_busy_cycles", busy_n, 16);
    chk("t1_high_cycles", hi_n, 6);

    // 2: two steps {1,3,2},{3,3,1}
    write_entry(0, 1, 3, 2);
    write_entry(1, 3, 3, 1);
    start_seq(2, 1'b0);
    measure(40);
    chk("t2_busy_cycles", busy_n, 14);
    chk("t2_high_cycles", hi_n, 5);
    chk("t2_load_cycles", load_n, 2);
    chk("t2_done_cycle", done_k, 16);

    // 3: middle step skipped (reps=0)
    write_entry(0, 2, 2, 1);
    write_entry(1, 1, 1, 0);
    write_entry(2, 1, 2, 2);
    start_seq(3, 1'b0);
    measure(40);
    chk("t3_busy_cycles", busy_n, 12);
    chk("t3_step1_run_cycles", run_step[1], 0);
    chk("t3_load_cycles", load_n, 3);
    chk("t3_high_cycles", hi_n, 4);
    chk("t3_done_cycle", done_k, 14);

    // 4: looping, then stop mid-period
    write_entry(0, 1, 1, 1);
    write_entry(1, 1, 2, 1);
    start_seq(2, 1'b1);
    wraps = 0; dn = 0; prev = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_done) dn++;
      if (o_busy && prev == 1 && o_step_idx == 3'd0) wraps++;
      prev = int'(o_step_idx);
    end
    chk("t4_no_done_while_looping", dn, 0);
    chk("t4_wrapped_twice", (wraps >= 2), 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (o_step_idx == 3'd1 && !o_pwm_sync && tb_hi) found = 1'b1;
    end
    chk("t4_reached_step1_high", found, 1'b1);
    @(posedge clk); #1 i_stop = 1'b1;
    @(posedge clk); #1 i_stop = 1'b0;
    @(negedge clk);
    chk("t4_stop_sync", o_pwm_sync, 1'b1);
    chk("t4_stop_pwm_low", tb_hi, 1'b0);
    chk("t4_stop_busy", o_busy, 1'b0);
    dn = 0;
    repeat (3) begin @(negedge clk); if (o_done) dn++; end
    chk("t4_stop_no_done", dn, 0);

    // 5: asynchronous reset mid-RUN, then rerun
    write_entry(0, 2, 4, 3);
    start_seq(1, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_busy", o_busy, 1'b0);
    chk("t5_rst_sync", o_pwm_sync, 1'b1);
    chk("t5_rst_duty", o_pwm_duty, 16'h0);
    chk("t5_rst_limit", o_pwm_limit, 16'h0);
    chk("t5_rst_step", o_step_idx, 3'h0);
    chk("t5_rst_done", o_done, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    start_seq(1, 1'b0);
    measure(40);
    chk("t5_rerun_first_high", first_hi_k, 3);
    chk("t5_rerun_done_cycle", done_k, 18);

    // 6: rewrite entry1 while step 0 runs
    write_entry(0, 1, 2, 2);
    write_entry(1, 1, 1, 1);
    start_seq(2, 1'b0);
    fork
      measure(60);
      write_entry(1, 2, 3, 2);
    join
    chk("t6_step1_run_cycles", run_step[1], 8);
    chk("t6_new_duty_cycles", d2_n, 8);
    chk("t6_done_cycle", done_k, 18);
`ifdef PWM_SEQ_IRQ_EN
    @(negedge clk);
    chk("t6_irq_after_done", o_irq, 1'b1);
    @(posedge clk); #1 i_irq_clr = 1'b1;
    @(posedge clk); #1 i_irq_clr = 1'b0;
    @(negedge clk);
    chk("t6_irq_cleared", o_irq, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
